// File: rtl/qar_dmem_responder.sv
// Data-memory responder for the QAR-Core external data port: word RAM behind a
// valid/ready handshake with zero, fixed or LFSR-driven wait-state insertion.
module qar_dmem_responder #(
  parameter int          DEPTH      = 256,
  parameter int          ADDR_WIDTH = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [31:0] OOR_RDATA  = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic [1:0]  wait_mode,
  input  logic [1:0]  wait_fixed,
  output logic        err,
  output logic [15:0] req_count
);

  // An all-zero LFSR would lock up, so a zero seed falls back to the default.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_reg;
  logic [1:0]              wcnt_reg;
  logic                    we_reg;
  logic                    oor_reg;
  logic [ADDR_WIDTH-1:0]   idx_reg;
  logic [31:0]             wdata_reg;
  logic [15:0]             lfsr_reg;
  logic                    ready_reg;
  logic [31:0]             rdata_reg;
  logic                    err_reg;
  logic [15:0]             count_reg;

  logic [31:0] ram [DEPTH];

  logic                  accept;
  logic                  complete;
  logic [1:0]            wcnt_load;
  logic                  in_oor;
  logic [ADDR_WIDTH-1:0] in_idx;
  logic                  txn_we;
  logic                  txn_oor;
  logic [ADDR_WIDTH-1:0] txn_idx;
  logic [31:0]           txn_wdata;
  logic                  lfsr_fb;
  logic                  unused_addr_bits;

  assign unused_addr_bits = &{1'b0, mem_addr[1:0]};

  assign in_idx  = mem_addr[ADDR_WIDTH+1:2];
  assign in_oor  = |mem_addr[31:ADDR_WIDTH+2];
  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  always_comb begin
    wcnt_load = 2'd0;
    case (wait_mode)
      2'b01:   wcnt_load = wait_fixed;
      2'b10:   wcnt_load = lfsr_reg[1:0];
      default: wcnt_load = 2'd0;
    endcase
  end

  assign accept   = (state_reg == IDLE) && mem_valid;
  assign complete = (accept && (wcnt_load == 2'd0)) ||
                    ((state_reg == WAIT) && (wcnt_reg == 2'd1));

  // A zero-wait transaction completes on its accept edge, before the latches
  // hold it, so the live request is used in that one case.
  assign txn_we    = accept ? mem_we    : we_reg;
  assign txn_oor   = accept ? in_oor    : oor_reg;
  assign txn_idx   = accept ? in_idx    : idx_reg;
  assign txn_wdata = accept ? mem_wdata : wdata_reg;

  always_ff @(posedge clk) begin
    if (complete && txn_we && !txn_oor) begin
      ram[txn_idx] <= txn_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      wcnt_reg  <= 2'd0;
      we_reg    <= 1'b0;
      oor_reg   <= 1'b0;
      idx_reg   <= '0;
      wdata_reg <= 32'h0;
      lfsr_reg  <= SEED_EFF;
      ready_reg <= 1'b0;
      rdata_reg <= 32'h0;
      err_reg   <= 1'b0;
      count_reg <= 16'h0;
    end else begin
      ready_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (mem_valid) begin
            we_reg    <= mem_we;
            oor_reg   <= in_oor;
            idx_reg   <= in_idx;
            wdata_reg <= mem_wdata;
            wcnt_reg  <= wcnt_load;
            lfsr_reg  <= {lfsr_reg[14:0], lfsr_fb};
            state_reg <= (wcnt_load != 2'd0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          wcnt_reg <= wcnt_reg - 2'd1;
          if (wcnt_reg == 2'd1) begin
            state_reg <= RESP;
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase

      if (complete) begin
        ready_reg <= 1'b1;
        count_reg <= count_reg + 16'd1;
        if (txn_oor) begin
          err_reg <= 1'b1;
        end
        if (!txn_we) begin
          rdata_reg <= txn_oor ? OOR_RDATA : ram[txn_idx];
        end
      end
    end
  end

  assign mem_ready = ready_reg;
  assign mem_rdata = rdata_reg;
  assign err       = err_reg;
  assign req_count = count_reg;

endmodule

// File: doc/qar_dmem_responder.md
Name: qar_dmem_responder

Overview:
- Synthesizable data-memory responder for the QAR-Core external data port (mem_valid/mem_we/mem_addr/mem_wdata -> mem_ready/mem_rdata).
- Word-addressed on-chip RAM behind a ready/valid handshake with selectable wait-state insertion: zero, fixed, or LFSR pseudo-random.
- Used when the core is built with USE_INTERNAL_DMEM=0, both in FPGA builds and as a stress responder in regressions.

Parameters:
- DEPTH, 256, number of 32-bit words in the RAM.
- ADDR_WIDTH, 8, word-index width; DEPTH must equal 2**ADDR_WIDTH.
- LFSR_SEED, 16'hACE1, reset value of the wait-state LFSR; a value of 0 is replaced by 16'hACE1.
- OOR_RDATA, 32'hDEADBEEF, read data returned for out-of-range addresses.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- mem_valid  input  1  request valid from the core; held high until mem_ready is seen.
- mem_we  input  1  1 = write, 0 = read; sampled at accept.
- mem_addr  input  32  byte address; sampled at accept.
- mem_wdata  input  32  write data; sampled at accept.
- mem_ready  output  1  single-cycle completion pulse.
- mem_rdata  output  32  read data; valid while mem_ready is high and held afterwards.
- wait_mode  input  2  00 = zero-wait, 01 = fixed (wait_fixed), 10 = random (lfsr[1:0]), 11 = same as 00; sampled at accept.
- wait_fixed  input  2  wait-cycle count used in mode 01.
- err  output  1  sticky flag; set on any out-of-range access, cleared only by reset.
- req_count  output  16  number of completed transactions, wraps 16'hFFFF -> 0.

Behaviour:
- Reset values (async): mem_ready=0, mem_rdata=0, err=0, req_count=0, state=IDLE, lfsr=LFSR_SEED. The RAM array is not reset; its contents are retained.
- Word index = mem_addr[ADDR_WIDTH+1:2]. mem_addr[1:0] is ignored; there are no byte lanes.
- Out-of-range access: mem_addr[31:ADDR_WIDTH+2] != 0. The write is dropped, a read returns OOR_RDATA, err is set on the completing edge, and the transaction still completes normally.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if mem_valid=1, accept. Latch we/addr/wdata and load wcnt (0, wait_fixed, or lfsr[1:0]). Go to WAIT if wcnt != 0, else RESP. The LFSR advances one step per accept only.
  - WAIT: decrement wcnt each cycle; go to RESP on the edge where wcnt == 1.
  - RESP: mem_ready=1 for exactly this cycle; unconditionally return to IDLE. mem_valid is ignored here, so the core's still-high valid is never re-accepted.
- Completing edge (IDLE->RESP or WAIT->RESP):
  - write: RAM updated.
  - read: mem_rdata loaded.
  - req_count incremented.
- mem_ready and mem_rdata are registered outputs with no combinational path from the inputs.
- Latency, counted from the accept edge to mem_ready high: 1 + W cycles, with W in 0..3. Throughput is one transaction per 2 + W cycles (accept, W waits, RESP).
- mem_rdata is unchanged by writes and by idle cycles.
- Read-after-write to the same word returns the new data, because the write commits before any later accept.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11, shift left with feedback into bit 0.
- Request inputs are don't-care after accept; the latched copies are used.
- Reset mid-transaction (WAIT or RESP): return to IDLE immediately with mem_ready=0. A pending write is discarded (RAM unchanged) and req_count is not incremented.

Test Plan:
- Zero-wait: mode 00; write 32'h12345678 to 0x40, then read 0x40 -> mem_ready 1 cycle after each accept, mem_rdata=32'h12345678, req_count=2.
- Fixed wait: mode 01, wait_fixed=3; read 0x0 -> mem_ready rises exactly 4 cycles after accept and stays high 1 cycle; valid held high in RESP causes no second accept, so req_count=1.
- Random wait: mode 10; 1000 back-to-back random read/write requests checked against a scoreboard -> all data matches, every latency is in 1..4 cycles, latency sequence matches a reference LFSR seeded 16'hACE1, req_count=1000.
- Out-of-range: write 32'hCAFEF00D to 0x400, then read 0x400 -> read returns 32'hDEADBEEF, err=1 and stays 1. Word 0 is not aliased (read 0x0 unchanged).
- Reset mid-write: mode 01, wait_fixed=3; write 32'hFFFFFFFF to 0x8 and assert rst_n=0 in the second WAIT cycle -> mem_ready never pulses, req_count=0; a later read of 0x8 returns the old value.
- Counter wrap: force req_count to 16'hFFFF, then complete one read -> req_count=0, mem_rdata correct.
